test_pattern_gen: RTL
=====================

// Module: test_pattern_gen
// PURPOSE
//  Self-contained, parametrised video test-pattern source: own H/V timing counters plus a
//  registered pixel pipeline with eight run-time selectable patterns and frame-count scrolling.
//  Drives both the SDL simulation outputs (hpos/vpos/visible/RGB) and real hsync/vsync.
//  Sits at top level between the clock/reset and the video DAC or SDL harness.
// PARAMETERS
//  H_VISIBLE 640  active pixels per line (multiple of 8)
//  H_FRONT 16 / H_SYNC 96 / H_BACK 48   horizontal porch/sync widths, pixels
//  V_VISIBLE 480  active lines per frame
//  V_FRONT 10 / V_SYNC 2 / V_BACK 33    vertical porch/sync widths, lines
//  COLOR_BITS 8   bits per colour channel
//  CHECKER_LOG2 5 log2 of checker cell / grid pitch in pixels
// PORTS
//  i_clk          in   1           pixel clock
//  i_rst_n        in   1           asynchronous reset, active low
//  i_mode         in   3           pattern select, sampled at frame end
//  i_scroll_en    in   1           enable frame counter advance
//  o_hsync        out  1           horizontal sync, active low
//  o_vsync        out  1           vertical sync, active low
//  o_hpos         out  10          pixel column of current output
//  o_vpos         out  10          pixel row of current output
//  o_visible      out  1           1 when (o_hpos,o_vpos) in active area
//  o_r/o_g/o_b    out  COLOR_BITS  pixel colour
//  o_frame_start  out  1           1-cycle pulse with pixel (0,0)
// BEHAVIOUR
//  - H_TOTAL=sum of H params (800), V_TOTAL=sum of V params (525).
//  - Stage 0: h_cnt 0..H_TOTAL-1, wraps to 0; v_cnt increments on h wrap, wraps after V_TOTAL-1.
//  - Stage 1 (all outputs registered): every output describes the stage-0 counter of previous
//    cycle; latency counter->pins = 1 clk; all outputs mutually aligned.
//  - hsync low for h in [H_VISIBLE+H_FRONT, +H_SYNC); vsync low for v in [V_VISIBLE+V_FRONT, +V_SYNC).
//  - visible = h<H_VISIBLE && v<V_VISIBLE; RGB forced to 0 when not visible.
//  - Reset (async, any time): counters 0, mode_q 0, frame_cnt 0, bar_idx 0; outputs hpos/vpos 0,
//    visible 0, RGB 0, hsync 1, vsync 1, frame_start 0. First output pixel (0,0) one clk after release.
//  - Frame end = stage-0 (H_TOTAL-1,V_TOTAL-1): mode_q<=i_mode; frame_cnt(8b)+=1 if i_scroll_en,
//    wraps 255->0. Mid-frame i_mode changes never affect the current frame.
//  - bar_idx (3b): cleared at h=0, incremented after every H_VISIBLE/8 pixels (sequential, no divider).
//  - "Full" = all COLOR_BITS ones. Patterns by mode_q:
//    0 colour bars: r=~bar_idx[1], g=~bar_idx[2], b=~bar_idx[0] at full scale
//      (white,yellow,cyan,green,magenta,red,blue,black).
//    1 checker: white if bit CHECKER_LOG2 of (h+frame_cnt) XOR of v is 0, else black.
//    2 grid: white if h[CHECKER_LOG2-1:0]==0 or v[..]==0 or h==H_VISIBLE-1 or v==V_VISIBLE-1.
//    3 gradient: r=(h+frame_cnt)[COLOR_BITS-1:0], g=v[COLOR_BITS-1:0], b=frame_cnt, zero-extended/truncated.
//    4 solid white, 5 solid red, 6 solid green, 7 solid blue.
//  - (h+frame_cnt) is 10-bit modulo add; scroll affects modes 1 and 3 only.
//  - frame_start=1 exactly when output hpos=0, vpos=0.
// TESTING
//  - Reset release, defaults -> frame_start first high 1 clk later; period 420000 clks.
//  - One line -> o_hsync low for exactly 96 clks, hpos 656..751; vsync low for 2 lines, vpos 490..491.
//  - Mode 0 -> (0,y)=FFFFFF, (80,y)=FFFF00, (639,y)=000000; (640,y) RGB 0 with visible 0.
//  - Mode 1, scroll off -> (31,0) white, (32,0) black, (32,32) white.
//  - i_mode 0->4 at vpos 100 -> remainder of frame still bars; next frame (0,0) = FFFFFF solid.
//  - Scroll on for 256 frames -> gradient r at (0,0) steps 0,1,..,255,0; assert i_rst_n mid-line
//    -> all outputs at reset values immediately, restart at (0,0).

Source files
------------

// File: rtl/test_pattern_gen.sv
// rtl/test_pattern_gen.sv - parametrised video timing and test-pattern source
// Stage 0 holds the H/V counters, and stage 1 registers every pin from them.
module test_pattern_gen #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int COLOR_BITS   = 8,
  parameter int CHECKER_LOG2 = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [2:0]            i_mode,
  input  logic                  i_scroll_en,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic [9:0]            o_hpos,
  output logic [9:0]            o_vpos,
  output logic                  o_visible,
  output logic [COLOR_BITS-1:0] o_r,
  output logic [COLOR_BITS-1:0] o_g,
  output logic [COLOR_BITS-1:0] o_b,
  output logic                  o_frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] H_EDGE   = 10'(H_VISIBLE - 1);
  localparam logic [9:0] V_EDGE   = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] BAR_LAST = 10'(H_VISIBLE / 8 - 1);

  localparam logic [COLOR_BITS-1:0] FULL = '1;

  logic [9:0]            h_cnt;
  logic [9:0]            v_cnt;
  logic [9:0]            bar_cnt;
  logic [2:0]            bar_idx;
  logic [2:0]            mode_q;
  logic [7:0]            frame_cnt;
  logic                  frame_end;
  logic [9:0]            h_scr;
  logic                  white;
  logic                  vis;
  logic [COLOR_BITS-1:0] pat_r;
  logic [COLOR_BITS-1:0] pat_g;
  logic [COLOR_BITS-1:0] pat_b;

  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign h_scr     = h_cnt + {2'b00, frame_cnt};
  assign vis       = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      bar_cnt   <= '0;
      bar_idx   <= '0;
      mode_q    <= '0;
      frame_cnt <= '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt   <= '0;
        bar_cnt <= '0;
        bar_idx <= '0;
        v_cnt   <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
        // bar_idx tracks h_cnt / (H_VISIBLE/8) without a divider; it keeps wrapping in blanking
        if (bar_cnt == BAR_LAST) begin
          bar_cnt <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + 10'd1;
        end
      end
      if (frame_end) begin
        mode_q <= i_mode;
        if (i_scroll_en) begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    white = 1'b0;
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    case (mode_q)
      3'd0: begin
        pat_r = bar_idx[1] ? '0 : FULL;
        pat_g = bar_idx[2] ? '0 : FULL;
        pat_b = bar_idx[0] ? '0 : FULL;
      end
      3'd1: white = ~(h_scr[CHECKER_LOG2] ^ v_cnt[CHECKER_LOG2]);
      3'd2: white = (h_cnt[CHECKER_LOG2-1:0] == '0) || (v_cnt[CHECKER_LOG2-1:0] == '0) ||
                    (h_cnt == H_EDGE) || (v_cnt == V_EDGE);
      3'd3: begin
        pat_r = COLOR_BITS'(h_scr);
        pat_g = COLOR_BITS'(v_cnt);
        pat_b = COLOR_BITS'(frame_cnt);
      end
      3'd4: white = 1'b1;
      3'd5: pat_r = FULL;
      3'd6: pat_g = FULL;
      default: pat_b = FULL;
    endcase
    if (white) begin
      pat_r = FULL;
      pat_g = FULL;
      pat_b = FULL;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_hpos        <= '0;
      o_vpos        <= '0;
      o_visible     <= 1'b0;
      o_r           <= '0;
      o_g           <= '0;
      o_b           <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_hsync       <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
      o_vsync       <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
      o_hpos        <= h_cnt;
      o_vpos        <= v_cnt;
      o_visible     <= vis;
      o_r           <= vis ? pat_r : '0;
      o_g           <= vis ? pat_g : '0;
      o_b           <= vis ? pat_b : '0;
      o_frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
  end

endmodule
